// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types for the systolic array operand feeders
package systolic_pkg;

    localparam int ELEM_BITS = 8;

    typedef logic signed [ELEM_BITS-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } feed_state_t;

endpackage

// File: rtl/skew_delay.sv
// rtl/skew_delay.sv - enable-gated data+valid shift line, DEPTH=0 is a wire
module skew_delay #(
    parameter int DEPTH = 1,
    parameter int BITS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [BITS-1:0] d,
    input  logic            dv,
    output logic [BITS-1:0] q,
    output logic            qv
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused;
            assign unused = &{1'b0, clk, rst_n, clr, en};
            assign q      = d;
            assign qv     = dv;
        end else begin : g_shift
            logic [BITS-1:0] sh  [DEPTH];
            logic [DEPTH-1:0] shv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) sh[i] <= '0;
                    shv <= '0;
                end else if (clr) begin
                    for (int i = 0; i < DEPTH; i++) sh[i] <= '0;
                    shv <= '0;
                end else if (en) begin
                    sh[0]  <= d;
                    shv[0] <= dv;
                    for (int i = 1; i < DEPTH; i++) begin
                        sh[i]  <= sh[i-1];
                        shv[i] <= shv[i-1];
                    end
                end
            end

            assign q  = sh[DEPTH-1];
            assign qv = shv[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/memb_skew_feeder.sv
// rtl/memb_skew_feeder.sv - streaming B-operand feeder producing the skewed wavefront
module memb_skew_feeder
    import systolic_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int ROWS    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*BITS_AB-1:0] Bin,
    input  logic                   adv,
    output logic [DIM*BITS_AB-1:0] Bout,
    output logic [DIM-1:0]         Bout_vld,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = $clog2(ROWS + 1);
    localparam int DW = $clog2(DIM + 1);

    feed_state_t      state, state_d;
    logic [RW-1:0]    row_cnt, row_d;
    logic [DW-1:0]    drain_cnt, drain_d;
    logic             fill, drain, step;
    logic [DIM*BITS_AB-1:0] line_q;
    logic [DIM-1:0]         line_qv;

    assign fill     = (state == FILL);
    assign drain    = (state == DRAIN);
    assign step     = adv & ((fill & in_valid) | drain);
    assign in_ready = fill & adv;
    assign busy     = (state != IDLE);

    // Column c sees c cycles of delay; draining pushes signed zeros with valid low.
    generate
        for (genvar c = 0; c < DIM; c++) begin : g_col
            skew_delay #(
                .DEPTH(c),
                .BITS (BITS_AB)
            ) u_dly (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (clr),
                .en   (step),
                .d    (fill ? Bin[c*BITS_AB +: BITS_AB] : {BITS_AB{1'b0}}),
                .dv   (fill),
                .q    (line_q[c*BITS_AB +: BITS_AB]),
                .qv   (line_qv[c])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Bout     <= '0;
            Bout_vld <= '0;
        end else if (clr) begin
            Bout     <= '0;
            Bout_vld <= '0;
        end else if (step) begin
            Bout     <= line_q;
            Bout_vld <= line_qv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
        end else if (clr) begin
            state     <= IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_d;
            row_cnt   <= row_d;
            drain_cnt <= drain_d;
        end
    end

    always_comb begin
        state_d = state;
        row_d   = row_cnt;
        drain_d = drain_cnt;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                if (step) begin
                    if (row_cnt == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        row_d = row_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (step) begin
                    if (drain_cnt == DW'(DIM - 1)) begin
                        drain_d = '0;
                        done    = ~clr;
                        state_d = start ? FILL : IDLE;
                    end else begin
                        drain_d = drain_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memb_skew_feeder.sv
// tb/tb_memb_skew_feeder.sv - scoreboard bench for memb_skew_feeder
module tb_memb_skew_feeder;

    localparam int DIM  = 4;
    localparam int ROWS = 4;
    localparam int B    = 8;

    logic clk = 1'b0;
    logic rst_n, clr, start, in_valid, adv;
    logic in_ready, busy, done;
    logic [DIM*B-1:0] Bin, Bout;
    logic [DIM-1:0]   Bout_vld;

    logic       c_start, c_valid;
    logic [7:0] c_bin, c_bout;
    logic [0:0] c_vld;
    logic       c_rdy, c_busy, c_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memb_skew_feeder #(.BITS_AB(B), .DIM(DIM), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .Bin(Bin), .adv(adv),
        .Bout(Bout), .Bout_vld(Bout_vld), .busy(busy), .done(done)
    );

    memb_skew_feeder #(.BITS_AB(8), .DIM(1), .ROWS(1)) u_corner (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .start(c_start),
        .in_valid(c_valid), .in_ready(c_rdy), .Bin(c_bin), .adv(1'b1),
        .Bout(c_bout), .Bout_vld(c_vld), .busy(c_busy), .done(c_done)
    );

    typedef struct {
        logic           done;
        logic           rdy;
        logic [DIM*B-1:0] bout;
        logic [DIM-1:0] vld;
        logic           busy;
    } exp_t;

    exp_t sb[$];

    int               m_phase, m_rows, m_drain, m_t;
    logic [DIM*B-1:0] mem [ROWS];
    logic [DIM*B-1:0] e_bout;
    logic [DIM-1:0]   e_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_rows = 0; m_drain = 0; m_t = 0;
        e_bout = '0; e_vld = '0;
    endtask

    function automatic logic [DIM*B-1:0] mkrow(input int r);
        logic [DIM*B-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*B +: B] = 8'(16*r + c);
        return v;
    endfunction

    function automatic logic [DIM*B-1:0] nrow(input int r);
        logic [DIM*B-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*B +: B] = ((c + r) % 2 == 1) ? 8'hFF : 8'h80;
        return v;
    endfunction

    // Reference: after tile step t, column c carries row t-c when that row exists.
    task automatic drive_cycle(input logic s_i, input logic v_i, input logic a_i,
                               input logic clr_i, input logic [DIM*B-1:0] row);
        exp_t e;
        bit   stp;
        int   st, r;
        @(posedge clk); #1;
        start = s_i; in_valid = v_i; adv = a_i; clr = clr_i; Bin = row;
        e.rdy  = (m_phase == 1) && a_i;
        e.done = 1'b0;
        stp    = a_i && ((m_phase == 1 && v_i) || m_phase == 2);
        if (clr_i) begin
            m_reset();
        end else if (m_phase == 0) begin
            if (s_i) begin m_phase = 1; m_rows = 0; m_t = 0; end
        end else if (stp) begin
            if (m_phase == 1) begin mem[m_rows] = row; m_rows++; end
            st = m_t;
            for (int c = 0; c < DIM; c++) begin
                r = st - c;
                if (r >= 0 && r < ROWS) begin
                    e_bout[c*B +: B] = mem[r][c*B +: B];
                    e_vld[c] = 1'b1;
                end else begin
                    e_bout[c*B +: B] = '0;
                    e_vld[c] = 1'b0;
                end
            end
            m_t++;
            if (m_phase == 1) begin
                if (m_rows == ROWS) begin m_phase = 2; m_drain = 0; end
            end else begin
                m_drain++;
                if (m_drain == DIM) begin
                    e.done = 1'b1;
                    m_phase = s_i ? 1 : 0;
                    m_rows = 0; m_t = 0;
                end
            end
        end
        e.bout = e_bout; e.vld = e_vld; e.busy = (m_phase != 0);
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done", done, e.done);
                chk("in_ready", in_ready, e.rdy);
                @(posedge clk); #2;
                chk("Bout", Bout, e.bout);
                chk("Bout_vld", Bout_vld, e.vld);
                chk("busy", busy, e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clr = 0; start = 0; in_valid = 0; adv = 0; Bin = '0;
        c_start = 0; c_valid = 0; c_bin = '0;
        m_reset();
        #12;
        chk("rst_Bout", Bout, 0);
        chk("rst_vld", Bout_vld, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        // basic tile
        drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < ROWS; r++) drive_cycle(0, 1, 1, 0, mkrow(r));
        for (int k = 0; k < DIM; k++) drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(0, 0, 1, 0, '0);

        // stalls mid-FILL and mid-DRAIN
        drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < 2; r++) drive_cycle(0, 1, 1, 0, mkrow(r));
        for (int k = 0; k < 3; k++) drive_cycle(0, 1, 0, 0, mkrow(2));
        for (int r = 2; r < ROWS; r++) drive_cycle(0, 1, 1, 0, mkrow(r));
        for (int k = 0; k < 2; k++) drive_cycle(0, 0, 1, 0, '0);
        for (int k = 0; k < 2; k++) drive_cycle(0, 0, 0, 0, '0);
        for (int k = 0; k < 2; k++) drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(0, 0, 1, 0, '0);

        // input bubbles
        drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < ROWS; r++) begin
            drive_cycle(0, 0, 1, 0, mkrow(9));
            drive_cycle(0, 1, 1, 0, mkrow(r));
        end
        for (int k = 0; k < DIM; k++) drive_cycle(0, 0, 1, 0, '0);

        // back-to-back with start held, negative values
        drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < ROWS; r++) drive_cycle(1, 1, 1, 0, nrow(r));
        for (int k = 0; k < DIM; k++) drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < ROWS; r++) drive_cycle(0, 1, 1, 0, mkrow(r + 4));
        for (int k = 0; k < DIM; k++) drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(0, 0, 1, 0, '0);

        // clr during DRAIN
        drive_cycle(1, 0, 1, 0, '0);
        for (int r = 0; r < ROWS; r++) drive_cycle(0, 1, 1, 0, mkrow(r));
        for (int k = 0; k < 2; k++) drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(0, 0, 1, 1, '0);
        drive_cycle(0, 0, 1, 0, '0);
        drive_cycle(0, 0, 1, 0, '0);

        // asynchronous reset mid-FILL
        drive_cycle(1, 0, 1, 0, '0);
        drive_cycle(0, 1, 1, 0, mkrow(0));
        drive_cycle(0, 1, 1, 0, mkrow(1));
        @(posedge clk); #3;
        in_valid = 0;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_Bout", Bout, 0);
        chk("arst_vld", Bout_vld, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        m_reset();
        drive_cycle(0, 0, 1, 0, '0);
        @(posedge clk); #3;
        chk("sb_empty", sb.size(), 0);

        // DIM=1, ROWS=1 build
        @(posedge clk); #1 c_start = 1;
        @(negedge clk); chk("c_idle_busy", c_busy, 0);
        @(posedge clk); #1 c_start = 0; c_valid = 1; c_bin = 8'hFB;
        chk("c_fill_busy", c_busy, 1);
        @(negedge clk); chk("c_rdy", c_rdy, 1);
        @(posedge clk); #1 c_valid = 0;
        chk("c_bout", c_bout, 8'hFB);
        chk("c_vld", c_vld, 1);
        @(negedge clk);
        chk("c_done", c_done, 1);
        chk("c_rdy_drain", c_rdy, 0);
        @(posedge clk); #1;
        chk("c_bout_end", c_bout, 0);
        chk("c_vld_end", c_vld, 0);
        chk("c_busy_end", c_busy, 0);
        chk("c_done_end", c_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
